// File: rtl/mod_counter_pkg.sv
// rtl/mod_counter_pkg.sv - shared op encoding and modulus helper for the modulo-N counter
package mod_counter_pkg;

    // Operation selected by the priority decoder for the current edge
    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_CLR  = 3'd1,
        OP_LD   = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4
    } op_e;

    // Terminal count of a modulo-N counter; callers truncate to their width
    function automatic int mod_max(input int modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// rtl/mod_counter_next.sv - next-state logic for count/co/bo (saturation under MOD_COUNTER_SAT_EN)
module mod_counter_next
    import mod_counter_pkg::*;
#(
    parameter int SIZE    = 10,
    parameter int MODULUS = 1 << SIZE
) (
    input  logic [SIZE-1:0] count,
    input  op_e             op,
    input  logic [SIZE-1:0] ld_val,
    input  logic            sat,
    output logic [SIZE-1:0] count_nxt,
    output logic            co_nxt,
    output logic            bo_nxt
);

    localparam logic [SIZE-1:0] MAX_CNT = SIZE'(mod_max(MODULUS));
    // MODULUS may equal 2^SIZE, so it needs one extra bit for the load clamp compare
    localparam logic [SIZE:0]   MOD_W   = (SIZE+1)'(MODULUS);

    logic            sat_on;
    logic [SIZE:0]   inc_w;
    logic [SIZE:0]   dec_w;
    logic            unused_msb;

`ifdef MOD_COUNTER_SAT_EN
    assign sat_on = sat;
`else
    // Saturation not built: the port remains for interface compatibility only
    logic unused_sat;
    assign unused_sat = sat;
    assign sat_on     = 1'b0;
`endif

    // Widened arithmetic; the top bit is never needed because bounds are checked first
    assign inc_w      = {1'b0, count} + {{SIZE{1'b0}}, 1'b1};
    assign dec_w      = {1'b0, count} - {{SIZE{1'b0}}, 1'b1};
    assign unused_msb = inc_w[SIZE] ^ dec_w[SIZE];

    // Select the next count and the wrap pulses for the decoded operation
    always_comb begin
        count_nxt = count;
        co_nxt    = 1'b0;
        bo_nxt    = 1'b0;
        case (op)
            OP_CLR: begin
                count_nxt = '0;
            end
            OP_LD: begin
                if ({1'b0, ld_val} >= MOD_W) begin
                    count_nxt = MAX_CNT;
                end else begin
                    count_nxt = ld_val;
                end
            end
            OP_INC: begin
                if (count == MAX_CNT) begin
                    if (!sat_on) begin
                        count_nxt = '0;
                        co_nxt    = 1'b1;
                    end
                end else begin
                    count_nxt = inc_w[SIZE-1:0];
                end
            end
            OP_DEC: begin
                if (count == '0) begin
                    if (!sat_on) begin
                        count_nxt = MAX_CNT;
                        bo_nxt    = 1'b1;
                    end
                end else begin
                    count_nxt = dec_w[SIZE-1:0];
                end
            end
            default: begin
                count_nxt = count;
            end
        endcase
    end

endmodule

// File: rtl/mod_updown_counter.sv
// rtl/mod_updown_counter.sv - modulo-N up/down counter, optional saturation via MOD_COUNTER_SAT_EN
module mod_updown_counter
    import mod_counter_pkg::*;
#(
    parameter int SIZE    = 10,
    parameter int MODULUS = 1 << SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            ld,
    input  logic [SIZE-1:0] ld_val,
    input  logic            inc,
    input  logic            dec,
    input  logic            sat,
    output logic [SIZE-1:0] count,
    output logic            co,
    output logic            bo,
    output logic            at_max,
    output logic            at_zero
);

    localparam logic [SIZE-1:0] MAX_CNT = SIZE'(mod_max(MODULUS));

    op_e             op;
    logic [SIZE-1:0] count_nxt;
    logic            co_nxt;
    logic            bo_nxt;

    // Priority decode: clear beats load beats a lone inc/dec; inc with dec is a no-op
    always_comb begin
        op = OP_HOLD;
        if (clr) begin
            op = OP_CLR;
        end else if (ld) begin
            op = OP_LD;
        end else if (inc ^ dec) begin
            op = inc ? OP_INC : OP_DEC;
        end
    end

    mod_counter_next #(
        .SIZE    (SIZE),
        .MODULUS (MODULUS)
    ) u_next (
        .count     (count),
        .op        (op),
        .ld_val    (ld_val),
        .sat       (sat),
        .count_nxt (count_nxt),
        .co_nxt    (co_nxt),
        .bo_nxt    (bo_nxt)
    );

    // State registers; co/bo are one-cycle pulses recomputed every edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            co    <= 1'b0;
            bo    <= 1'b0;
        end else begin
            count <= count_nxt;
            co    <= co_nxt;
            bo    <= bo_nxt;
        end
    end

    assign at_max  = (count == MAX_CNT);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// tb/tb_mod_updown_counter.sv - randomized and directed check of mod_updown_counter against a reference model
module tb_mod_updown_counter;

    localparam int SIZE    = 4;
    localparam int MODULUS = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            clr = 1'b0;
    logic            ld  = 1'b0;
    logic [SIZE-1:0] ld_val = '0;
    logic            inc = 1'b0;
    logic            dec = 1'b0;
    logic            sat = 1'b0;
    logic [SIZE-1:0] count;
    logic            co;
    logic            bo;
    logic            at_max;
    logic            at_zero;

    int vectors   = 0;
    int miscompares = 0;

    // Reference state
    int m_count = 0;
    int m_co    = 0;
    int m_bo    = 0;

`ifdef MOD_COUNTER_SAT_EN
    localparam bit SAT_BUILT = 1'b1;
`else
    localparam bit SAT_BUILT = 1'b0;
`endif

    always #5 clk = ~clk;

    mod_updown_counter #(
        .SIZE    (SIZE),
        .MODULUS (MODULUS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .ld      (ld),
        .ld_val  (ld_val),
        .inc     (inc),
        .dec     (dec),
        .sat     (sat),
        .count   (count),
        .co      (co),
        .bo      (bo),
        .at_max  (at_max),
        .at_zero (at_zero)
    );

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"},   int'(count),   m_count);
        check({tag, ".co"},      int'(co),      m_co);
        check({tag, ".bo"},      int'(bo),      m_bo);
        check({tag, ".at_max"},  int'(at_max),  (m_count == MODULUS - 1) ? 1 : 0);
        check({tag, ".at_zero"}, int'(at_zero), (m_count == 0) ? 1 : 0);
    endtask

    // Reference behaviour expressed with modular arithmetic on integers
    task automatic model_edge(input bit c, input bit l, input int lv, input bit i, input bit d, input bit s);
        bit saturating;
        saturating = SAT_BUILT && s;
        m_co = 0;
        m_bo = 0;
        if (c) begin
            m_count = 0;
        end else if (l) begin
            m_count = (lv >= MODULUS) ? MODULUS - 1 : lv;
        end else if (i && !d) begin
            if (m_count == MODULUS - 1 && saturating) begin
                m_count = m_count;
            end else begin
                m_co    = (m_count == MODULUS - 1) ? 1 : 0;
                m_count = (m_count + 1) % MODULUS;
            end
        end else if (d && !i) begin
            if (m_count == 0 && saturating) begin
                m_count = 0;
            end else begin
                m_bo    = (m_count == 0) ? 1 : 0;
                m_count = (m_count + MODULUS - 1) % MODULUS;
            end
        end
    endtask

    task automatic step(input string tag, input bit c, input bit l, input int lv,
                        input bit i, input bit d, input bit s);
        @(negedge clk);
        clr    = c;
        ld     = l;
        ld_val = SIZE'(lv);
        inc    = i;
        dec    = d;
        sat    = s;
        @(posedge clk);
        model_edge(c, l, lv, i, d, s);
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset held: outputs at reset values
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Ten increments: 1..9 then wrap to 0 with co
        for (int k = 0; k < 10; k++) step("inc_run", 0, 0, 0, 1, 0, 0);
        step("co_drop", 0, 0, 0, 0, 0, 0);

        // Decrement from 0 borrows to 9, then 8 with bo low
        step("dec_wrap", 0, 0, 0, 0, 1, 0);
        step("dec_again", 0, 0, 0, 0, 1, 0);

        // Load clamp and clear priority
        step("ld_clamp", 0, 1, 12, 0, 0, 0);
        step("clr_over_ld", 1, 1, 12, 0, 0, 0);
        step("ld_15", 0, 1, 15, 1, 0, 0);
        step("ld_9", 0, 1, 9, 0, 0, 0);

        // inc and dec together hold
        step("ld_5", 0, 1, 5, 0, 0, 0);
        for (int k = 0; k < 3; k++) step("inc_dec", 0, 0, 0, 1, 1, 0);

        // sat=1 at bounds: holds when built with saturation, wraps otherwise
        step("ld_9s", 0, 1, 9, 0, 0, 0);
        step("sat_inc", 0, 0, 0, 1, 0, 1);
        step("ld_0s", 0, 1, 0, 0, 0, 0);
        step("sat_dec", 0, 0, 0, 0, 1, 1);

        // Async reset between edges while co is high
        step("ld_9r", 0, 1, 9, 0, 0, 0);
        step("wrap_r", 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        inc = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_count = 0; m_co = 0; m_bo = 0;
        check_all("async_rst_co");
        #1 rst = 1'b0;
        step("post_rst_inc", 0, 0, 0, 1, 0, 0);

        // Async reset at count 7
        step("ld_7", 0, 1, 7, 0, 0, 0);
        @(negedge clk);
        ld = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_count = 0; m_co = 0; m_bo = 0;
        check_all("async_rst_7");
        #1 rst = 1'b0;
        step("post_rst7_inc", 0, 0, 0, 1, 0, 0);

        // Randomized traffic weighted toward counting
        for (int k = 0; k < 400; k++) begin
            bit c, l, i, d, s;
            int lv;
            c  = ($urandom_range(0, 19) == 0);
            l  = ($urandom_range(0, 9) == 0);
            lv = $urandom_range(0, (1 << SIZE) - 1);
            i  = ($urandom_range(0, 2) != 0);
            d  = ($urandom_range(0, 2) == 0);
            s  = $urandom_range(0, 1);
            step("random", c, l, lv, i, d, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
